// File: rtl/cde_jtag_pkg.sv
// Shared JTAG TAP definitions: standard 4-bit state encoding and IR capture value.
package cde_jtag_pkg;

    localparam int unsigned TAP_STATE_BITS = 4;

    typedef enum logic [TAP_STATE_BITS-1:0] {
        TAP_EX2DR = 4'h0,
        TAP_EX1DR = 4'h1,
        TAP_SHDR  = 4'h2,
        TAP_PAUDR = 4'h3,
        TAP_SELIR = 4'h4,
        TAP_UPDDR = 4'h5,
        TAP_CAPDR = 4'h6,
        TAP_SELDR = 4'h7,
        TAP_EX2IR = 4'h8,
        TAP_EX1IR = 4'h9,
        TAP_SHIR  = 4'hA,
        TAP_PAUIR = 4'hB,
        TAP_RTI   = 4'hC,
        TAP_UPDIR = 4'hD,
        TAP_CAPIR = 4'hE,
        TAP_TLR   = 4'hF
    } tap_state_e;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/cde_jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: tracks the 16-state controller from tms on each TCK rise.
module cde_jtag_tap_fsm
    import cde_jtag_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      tms,
    output logic [TAP_STATE_BITS-1:0] state
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard tms-driven transitions; five tms=1 reach TLR from anywhere.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TAP_TLR:   state_d = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   state_d = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: state_d = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: state_d = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  state_d = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: state_d = tms ? TAP_UPDDR : TAP_PAUDR;
            TAP_PAUDR: state_d = tms ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: state_d = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR: state_d = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: state_d = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: state_d = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  state_d = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: state_d = tms ? TAP_UPDIR : TAP_PAUIR;
            TAP_PAUIR: state_d = tms ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: state_d = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR: state_d = tms ? TAP_SELDR : TAP_RTI;
            default:   state_d = TAP_TLR;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/cde_jtag_rpc_tap.sv
// TAP controller for the RPC register chain: IR, bypass, one-hot DR select and tdo mux.
module cde_jtag_rpc_tap
    import cde_jtag_pkg::*;
#(
    parameter int unsigned          IR_BITS  = 4,
    parameter int unsigned          NUM_DR   = 4,
    parameter logic [IR_BITS-1:0]   IR_RESET = '1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tms,
    input  logic               tdi,
    input  logic [NUM_DR-1:0]  dr_tdo,
    output logic               capture_dr,
    output logic               shift_dr,
    output logic               update_dr,
    output logic [NUM_DR-1:0]  select,
    output logic [IR_BITS-1:0] ir,
    output logic               tdo,
    output logic               tdo_en
);

    logic [TAP_STATE_BITS-1:0] state_raw;
    tap_state_e                state;
    logic [IR_BITS-1:0]        ir_shift;
    logic                      bypass;
    logic                      is_bypass;
    logic                      dr_hit;
    logic                      in_shift_ir;

    cde_jtag_tap_fsm u_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .tms     (tms),
        .state   (state_raw)
    );

    assign state = tap_state_e'(state_raw);

    // Strobes decode the registered state, so each is high for exactly its state's cycles.
    assign capture_dr  = (state == TAP_CAPDR);
    assign shift_dr    = (state == TAP_SHDR);
    assign update_dr   = (state == TAP_UPDDR);
    assign in_shift_ir = (state == TAP_SHIR);
    assign tdo_en      = shift_dr | in_shift_ir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir       <= IR_RESET;
            ir_shift <= '0;
            bypass   <= 1'b0;
        end else begin
            if (state == TAP_TLR) begin
                ir <= IR_RESET;
            end else if (state == TAP_UPDIR) begin
                ir <= ir_shift;
            end

            if (state == TAP_CAPIR) begin
                ir_shift <= IR_BITS'(IR_CAPTURE);
            end else if (in_shift_ir) begin
                ir_shift <= {tdi, ir_shift[IR_BITS-1:1]};
            end

            if (capture_dr && is_bypass) begin
                bypass <= 1'b0;
            end else if (shift_dr && is_bypass) begin
                bypass <= tdi;
            end
        end
    end

    // One-hot decode; any IR value without a register behind it is BYPASS.
    always_comb begin
        select = '0;
        for (int k = 0; k < int'(NUM_DR); k++) begin
            select[k] = (ir == IR_BITS'(k));
        end
    end

    assign is_bypass = ~|select;
    assign dr_hit    = |(dr_tdo & select);

    always_comb begin
        tdo = 1'b0;
        if (in_shift_ir) begin
            tdo = ir_shift[0];
        end else if (shift_dr) begin
            tdo = is_bypass ? bypass : dr_hit;
        end
    end

endmodule

// File: tb/tb_cde_jtag_rpc_tap.sv
// Directed bench for cde_jtag_rpc_tap: reset, IR load, DR scan, bypass, pause and mid-shift reset.
module tb_cde_jtag_rpc_tap;

    logic       clk;
    logic       reset_n;
    logic       tms;
    logic       tdi;
    logic [3:0] dr_tdo;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic [3:0] select;
    logic [3:0] ir;
    logic       tdo;
    logic       tdo_en;

    int errors = 0;
    int checks = 0;

    cde_jtag_rpc_tap #(
        .IR_BITS  (4),
        .NUM_DR   (4),
        .IR_RESET (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tms        (tms),
        .tdi        (tdi),
        .dr_tdo     (dr_tdo),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .select     (select),
        .ir         (ir),
        .tdo        (tdo),
        .tdo_en     (tdo_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Apply tms/tdi, take one TCK rise, settle just after it.
    task automatic tick(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        #1;
    endtask

    // Load an instruction starting from RTI, ending back in RTI; no checking.
    task automatic load_ir(input logic [3:0] v);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tms = 1'b1;
        tdi = 1'b0;
        dr_tdo = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ir !== 4'hF) begin errors++; $display("FAIL reset_ir: got %h expected %h", ir, 4'hF); end
        checks++; if (select !== 4'h0) begin errors++; $display("FAIL reset_select: got %b expected %b", select, 4'h0); end
        checks++; if ({capture_dr, shift_dr, update_dr, tdo_en, tdo} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected %b", {capture_dr, shift_dr, update_dr, tdo_en, tdo}, 5'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++; if (capture_dr !== 1'b1) begin errors++; $display("FAIL reset_capdr: got %b expected 1", capture_dr); end
        repeat (5) tick(1'b1, 1'b0);
        checks++; if ({ir, select, tdo_en} !== {4'hF, 4'h0, 1'b0}) begin
            errors++; $display("FAIL tlr_five_ones: got ir=%h sel=%b en=%b expected ir=f sel=0000 en=0", ir, select, tdo_en);
        end
        // From TLR, tms 0,1,0 must land in Capture-DR.
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++; if (capture_dr !== 1'b1) begin errors++; $display("FAIL tlr_reached: got capture_dr=%b expected 1", capture_dr); end
        repeat (5) tick(1'b1, 1'b0);
    endtask

    task automatic test_ir_load();
        logic [3:0] bits;
        logic [3:0] exp_tdo;
        bits = 4'b0010;
        exp_tdo = 4'b0001;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (tdo_en !== 1'b1) begin errors++; $display("FAIL ir_tdo_en[%0d]: got %b expected 1", i, tdo_en); end
            checks++; if (tdo !== exp_tdo[i]) begin errors++; $display("FAIL ir_tdo[%0d]: got %b expected %b", i, tdo, exp_tdo[i]); end
            tick(i == 3, bits[i]);
        end
        checks++; if (tdo_en !== 1'b0) begin errors++; $display("FAIL ir_ex1_en: got %b expected 0", tdo_en); end
        tick(1'b1, 1'b0);
        checks++; if (ir !== 4'hF) begin errors++; $display("FAIL ir_before_upd: got %h expected f", ir); end
        tick(1'b0, 1'b0);
        checks++; if (ir !== 4'h2) begin errors++; $display("FAIL ir_loaded: got %h expected 2", ir); end
        checks++; if (select !== 4'b0100) begin errors++; $display("FAIL ir_select: got %b expected 0100", select); end
    endtask

    task automatic test_dr_scan();
        logic [15:0] pat;
        logic        p;
        int          shift_cnt;
        int          cap_cnt;
        pat = 16'hA5C3;
        shift_cnt = 0;
        cap_cnt = 0;
        tick(1'b1, 1'b0);
        if (capture_dr) cap_cnt++;
        tick(1'b0, 1'b0);
        if (capture_dr) cap_cnt++;
        checks++; if (shift_dr !== 1'b0) begin errors++; $display("FAIL dr_capdr_shift: got %b expected 0", shift_dr); end
        tick(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            p = pat[i];
            dr_tdo = {~p, p, ~p, ~p};
            #1;
            if (capture_dr) cap_cnt++;
            if (shift_dr) shift_cnt++;
            checks++; if (tdo !== p) begin errors++; $display("FAIL dr_tdo[%0d]: got %b expected %b", i, tdo, p); end
            tick(i == 15, 1'b0);
        end
        checks++; if (cap_cnt !== 1) begin errors++; $display("FAIL dr_capture_cycles: got %0d expected 1", cap_cnt); end
        checks++; if (shift_cnt !== 16) begin errors++; $display("FAIL dr_shift_cycles: got %0d expected 16", shift_cnt); end
        checks++; if ({shift_dr, update_dr, tdo_en} !== 3'b000) begin
            errors++; $display("FAIL dr_ex1: got %b expected 000", {shift_dr, update_dr, tdo_en});
        end
        tick(1'b1, 1'b0);
        checks++; if (update_dr !== 1'b1) begin errors++; $display("FAIL dr_update: got %b expected 1", update_dr); end
        tick(1'b0, 1'b0);
        checks++; if (update_dr !== 1'b0) begin errors++; $display("FAIL dr_update_once: got %b expected 0", update_dr); end
        checks++; if ({ir, select} !== {4'h2, 4'b0100}) begin
            errors++; $display("FAIL dr_ir_stable: got ir=%h sel=%b expected ir=2 sel=0100", ir, select);
        end
        dr_tdo = 4'h0;
    endtask

    task automatic test_bypass();
        logic [3:0] in_bits;
        logic [3:0] exp_tdo;
        in_bits = 4'b1101;
        exp_tdo = 4'b1010;
        load_ir(4'hF);
        checks++; if ({ir, select} !== {4'hF, 4'h0}) begin
            errors++; $display("FAIL byp_ir: got ir=%h sel=%b expected ir=f sel=0000", ir, select);
        end
        dr_tdo = 4'hF;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (tdo !== exp_tdo[i]) begin errors++; $display("FAIL byp_tdo[%0d]: got %b expected %b", i, tdo, exp_tdo[i]); end
            tick(1'b0, in_bits[i]);
        end
    endtask

    task automatic test_pause();
        // Still in Shift-DR under BYPASS with bypass = 1.
        checks++; if (tdo !== 1'b1) begin errors++; $display("FAIL pause_pre: got %b expected 1", tdo); end
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({shift_dr, tdo_en, tdo} !== 3'b000) begin
                errors++; $display("FAIL pause_hold[%0d]: got %b expected 000", i, {shift_dr, tdo_en, tdo});
            end
            tick(i == 2, 1'b0);
        end
        checks++; if (shift_dr !== 1'b0) begin errors++; $display("FAIL pause_ex2: got %b expected 0", shift_dr); end
        tick(1'b0, 1'b0);
        checks++; if ({shift_dr, tdo} !== 2'b11) begin
            errors++; $display("FAIL pause_resume: got %b expected 11", {shift_dr, tdo});
        end
        tick(1'b0, 1'b0);
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL pause_shift: got %b expected 0", tdo); end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        dr_tdo = 4'h0;
    endtask

    task automatic test_reset_mid_shift();
        logic [3:0] bits;
        logic [3:0] exp_tdo;
        logic [3:0] pat;
        logic       p;
        load_ir(4'h1);
        checks++; if (select !== 4'b0010) begin errors++; $display("FAIL mid_pre_select: got %b expected 0010", select); end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++; if ({tdo_en, tdo} !== 2'b10) begin errors++; $display("FAIL mid_pre_tdo: got %b expected 10", {tdo_en, tdo}); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({tdo_en, tdo} !== 2'b00) begin errors++; $display("FAIL mid_rst_tdo: got %b expected 00", {tdo_en, tdo}); end
        checks++; if ({ir, select} !== {4'hF, 4'h0}) begin
            errors++; $display("FAIL mid_rst_ir: got ir=%h sel=%b expected ir=f sel=0000", ir, select);
        end
        tms = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bits = 4'b0011;
        exp_tdo = 4'b0001;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (tdo !== exp_tdo[i]) begin errors++; $display("FAIL rec_ir_tdo[%0d]: got %b expected %b", i, tdo, exp_tdo[i]); end
            tick(i == 3, bits[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++; if ({ir, select} !== {4'h3, 4'b1000}) begin
            errors++; $display("FAIL rec_ir: got ir=%h sel=%b expected ir=3 sel=1000", ir, select);
        end
        pat = 4'b1001;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            p = pat[i];
            dr_tdo = {p, ~p, ~p, ~p};
            #1;
            checks++; if (tdo !== p) begin errors++; $display("FAIL rec_dr_tdo[%0d]: got %b expected %b", i, tdo, p); end
            tick(i == 3, 1'b0);
        end
        tick(1'b1, 1'b0);
        checks++; if (update_dr !== 1'b1) begin errors++; $display("FAIL rec_update: got %b expected 1", update_dr); end
        tick(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ir_load();
        test_dr_scan();
        test_bypass();
        test_pause();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
